// File: rtl/regblock_arbiter.sv
// rtl/regblock_arbiter.sv - round-robin arbiter sharing one register_block port among N_REQ requesters
// Optional REGARB_WPROT_EN: reject writes to the read-only ID register at address 0 (flagged on o_err).
module regblock_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ-1:0]       i_we,
  input  logic [N_REQ*AW-1:0]    i_addr,
  input  logic [N_REQ*WIDTH-1:0] i_wdata,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_done,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_err,
  output logic                   o_busy,
  output logic                   o_w_en,
  output logic [AW-1:0]          o_w_addr,
  output logic [WIDTH-1:0]       o_w_value,
  output logic                   o_r_en,
  output logic [AW-1:0]          o_r_addr,
  input  logic [WIDTH-1:0]       i_r_value,
  input  logic                   i_r_valid
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT_R, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic             w_en_q, w_en_d, r_en_q, r_en_d, busy_q, busy_d;
  logic             found;
  logic [PW-1:0]    win;

`ifdef REGARB_WPROT_EN
  logic reject_q, reject_d, err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    w_en_d   = 1'b0;
    r_en_d   = 1'b0;
`ifdef REGARB_WPROT_EN
    reject_d = reject_q;
    err_d    = 1'b0;
`endif
    found    = 1'b0;
    win      = '0;

    // Search begins just after the last owner so every requester gets a turn.
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && i_req[(int'(rr_ptr_q) + i) % N_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_CMD;
          rr_ptr_d = win;
          gnt_d    = N_REQ'(1) << win;
          we_d     = i_we[win];
          addr_d   = i_addr[int'(win)*AW +: AW];
          wdata_d  = i_wdata[int'(win)*WIDTH +: WIDTH];
`ifdef REGARB_WPROT_EN
          reject_d = i_we[win] && (addr_d == '0);
          w_en_d   = i_we[win] && !reject_d;
`else
          w_en_d   = i_we[win];
`endif
          r_en_d   = !i_we[win];
        end
      end
      S_CMD: begin
        if (we_q) begin
          state_d = S_DONE;
          done_d  = gnt_q;
`ifdef REGARB_WPROT_EN
          err_d   = reject_q;
`endif
        end else begin
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (i_r_valid) begin
          state_d = S_DONE;
          rdata_d = i_r_value;
          done_d  = gnt_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= PW'(N_REQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      w_en_q   <= 1'b0;
      r_en_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef REGARB_WPROT_EN
      reject_q <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      w_en_q   <= w_en_d;
      r_en_q   <= r_en_d;
      busy_q   <= busy_d;
`ifdef REGARB_WPROT_EN
      reject_q <= reject_d;
      err_q    <= err_d;
`endif
    end
  end

  assign o_gnt     = gnt_q;
  assign o_done    = done_q;
  assign o_rdata   = rdata_q;
  assign o_busy    = busy_q;
  assign o_w_en    = w_en_q;
  assign o_w_addr  = addr_q;
  assign o_w_value = wdata_q;
  assign o_r_en    = r_en_q;
  assign o_r_addr  = addr_q;
`ifdef REGARB_WPROT_EN
  assign o_err     = err_q;
`else
  assign o_err     = 1'b0;
`endif

endmodule
